// File: rtl/axi_lite_arbiter_if.sv
// AXI4-Lite signal bundle: 32-bit address/data, 4-bit write mask, single-beat channels.
// The master modport drives requests; the slave modport drives ready/response signals.
interface axi_lite_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wmask, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wmask, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_arbiter.sv
// Round-robin 2:1 AXI4-Lite arbiter (m0 = IFU, m1 = LSU) with one transaction in flight.
// The grant is registered, so a new request never reaches the slave port in the cycle it appears.
module axi_lite_arbiter #(
  parameter logic RESET_LAST = 1'b1
) (
  input logic        clk,
  input logic        reset,
  axi_lite_if.slave  m0,
  axi_lite_if.slave  m1,
  axi_lite_if.master s
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_M0 = 3'd1,
    RD_M1 = 3'd2,
    WR_M0 = 3'd3,
    WR_M1 = 3'd4
  } state_t;

  state_t state_r;
  logic   last_grant_r;
  logic   aw_done_r;   // doubles as "AR accepted" while in a read state
  logic   w_done_r;

  logic req0_s, req1_s, win_m1_s, win_rd_s;
  logic rd_m0_s, rd_m1_s, wr_m0_s, wr_m1_s, rd_act_s, wr_act_s, gnt_m1_s;
  logic ar_hs_s, r_hs_s, aw_hs_s, w_hs_s, b_hs_s;

  logic [31:0] sel_araddr_s, sel_awaddr_s, sel_wdata_s;
  logic [3:0]  sel_wmask_s;
  logic        sel_arvalid_s, sel_rready_s, sel_awvalid_s, sel_wvalid_s, sel_bready_s;

  // Request decode and winner selection for the next arbitration
  always_comb begin
    req0_s   = m0.arvalid | m0.awvalid;
    req1_s   = m1.arvalid | m1.awvalid;
    win_m1_s = req1_s & (~req0_s | ~last_grant_r);
    win_rd_s = win_m1_s ? m1.arvalid : m0.arvalid;
  end

  // State decode shared by the muxes and the handshake detection
  always_comb begin
    rd_m0_s  = (state_r == RD_M0);
    rd_m1_s  = (state_r == RD_M1);
    wr_m0_s  = (state_r == WR_M0);
    wr_m1_s  = (state_r == WR_M1);
    rd_act_s = rd_m0_s | rd_m1_s;
    wr_act_s = wr_m0_s | wr_m1_s;
    gnt_m1_s = rd_m1_s | wr_m1_s;
  end

  // Request-side fields of whichever master currently holds the grant
  always_comb begin
    sel_araddr_s  = gnt_m1_s ? m1.araddr  : m0.araddr;
    sel_arvalid_s = gnt_m1_s ? m1.arvalid : m0.arvalid;
    sel_rready_s  = gnt_m1_s ? m1.rready  : m0.rready;
    sel_awaddr_s  = gnt_m1_s ? m1.awaddr  : m0.awaddr;
    sel_awvalid_s = gnt_m1_s ? m1.awvalid : m0.awvalid;
    sel_wdata_s   = gnt_m1_s ? m1.wdata   : m0.wdata;
    sel_wmask_s   = gnt_m1_s ? m1.wmask   : m0.wmask;
    sel_wvalid_s  = gnt_m1_s ? m1.wvalid  : m0.wvalid;
    sel_bready_s  = gnt_m1_s ? m1.bready  : m0.bready;
  end

  // Slave-port request channels; zero whenever nothing is granted
  always_comb begin
    s.araddr  = rd_act_s ? sel_araddr_s : 32'h0;
    s.arvalid = rd_act_s & sel_arvalid_s & ~aw_done_r;
    s.rready  = rd_act_s & sel_rready_s;
    s.awaddr  = wr_act_s ? sel_awaddr_s : 32'h0;
    s.awvalid = wr_act_s & sel_awvalid_s & ~aw_done_r;
    s.wdata   = wr_act_s ? sel_wdata_s : 32'h0;
    s.wmask   = wr_act_s ? sel_wmask_s : 4'h0;
    s.wvalid  = wr_act_s & sel_wvalid_s & ~w_done_r;
    s.bready  = wr_act_s & sel_bready_s;
  end

  // Handshakes seen on the slave port
  always_comb begin
    ar_hs_s = s.arvalid & s.arready;
    r_hs_s  = s.rvalid  & s.rready;
    aw_hs_s = s.awvalid & s.awready;
    w_hs_s  = s.wvalid  & s.wready;
    b_hs_s  = s.bvalid  & s.bready;
  end

  // Master 0 response path; responses are passed through unchanged, errors included
  always_comb begin
    m0.arready = rd_m0_s & s.arready & ~aw_done_r;
    m0.rvalid  = rd_m0_s & s.rvalid;
    m0.rdata   = rd_m0_s ? s.rdata : 32'h0;
    m0.rresp   = rd_m0_s ? s.rresp : 2'b00;
    m0.awready = wr_m0_s & s.awready & ~aw_done_r;
    m0.wready  = wr_m0_s & s.wready & ~w_done_r;
    m0.bvalid  = wr_m0_s & s.bvalid;
    m0.bresp   = wr_m0_s ? s.bresp : 2'b00;
  end

  // Master 1 response path
  always_comb begin
    m1.arready = rd_m1_s & s.arready & ~aw_done_r;
    m1.rvalid  = rd_m1_s & s.rvalid;
    m1.rdata   = rd_m1_s ? s.rdata : 32'h0;
    m1.rresp   = rd_m1_s ? s.rresp : 2'b00;
    m1.awready = wr_m1_s & s.awready & ~aw_done_r;
    m1.wready  = wr_m1_s & s.wready & ~w_done_r;
    m1.bvalid  = wr_m1_s & s.bvalid;
    m1.bresp   = wr_m1_s ? s.bresp : 2'b00;
  end

  // Arbitration FSM with round-robin pointer and per-channel completion flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      last_grant_r <= RESET_LAST;
      aw_done_r    <= 1'b0;
      w_done_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          aw_done_r <= 1'b0;
          w_done_r  <= 1'b0;
          if (req0_s | req1_s) begin
            last_grant_r <= win_m1_s;
            if (win_rd_s) begin
              state_r <= win_m1_s ? RD_M1 : RD_M0;
            end else begin
              state_r <= win_m1_s ? WR_M1 : WR_M0;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RD_M0, RD_M1: begin
          if (r_hs_s) begin
            state_r   <= IDLE;
            aw_done_r <= 1'b0;
          end else if (ar_hs_s) begin
            aw_done_r <= 1'b1;
          end else begin
            aw_done_r <= aw_done_r;
          end
        end
        WR_M0, WR_M1: begin
          if (b_hs_s) begin
            state_r   <= IDLE;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
          end else begin
            aw_done_r <= aw_done_r | aw_hs_s;
            w_done_r  <= w_done_r | w_hs_s;
          end
        end
        default: begin
          state_r   <= IDLE;
          aw_done_r <= 1'b0;
          w_done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Randomized bench for axi_lite_arbiter: transaction-level round-robin model, reactive slave,
// and directed cases for grant latency, late/early W, async reset mid-read.
module tb_axi_lite_arbiter;

  localparam int LIM = 200;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axi_lite_if m0_if ();
  axi_lite_if m1_if ();
  axi_lite_if s_if ();

  axi_lite_arbiter #(.RESET_LAST(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
  endtask

  // ---------------- master-side drive ----------------
  logic [1:0]  m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
  logic [31:0] m_araddr [2];
  logic [31:0] m_awaddr [2];
  logic [31:0] m_wdata  [2];
  logic [3:0]  m_wmask  [2];

  assign m0_if.arvalid = m_arvalid[0]; assign m1_if.arvalid = m_arvalid[1];
  assign m0_if.araddr  = m_araddr[0];  assign m1_if.araddr  = m_araddr[1];
  assign m0_if.rready  = m_rready[0];  assign m1_if.rready  = m_rready[1];
  assign m0_if.awvalid = m_awvalid[0]; assign m1_if.awvalid = m_awvalid[1];
  assign m0_if.awaddr  = m_awaddr[0];  assign m1_if.awaddr  = m_awaddr[1];
  assign m0_if.wvalid  = m_wvalid[0];  assign m1_if.wvalid  = m_wvalid[1];
  assign m0_if.wdata   = m_wdata[0];   assign m1_if.wdata   = m_wdata[1];
  assign m0_if.wmask   = m_wmask[0];   assign m1_if.wmask   = m_wmask[1];
  assign m0_if.bready  = m_bready[0];  assign m1_if.bready  = m_bready[1];

  wire [1:0] m_arready = {m1_if.arready, m0_if.arready};
  wire [1:0] m_rvalid  = {m1_if.rvalid,  m0_if.rvalid};
  wire [1:0] m_awready = {m1_if.awready, m0_if.awready};
  wire [1:0] m_wready  = {m1_if.wready,  m0_if.wready};
  wire [1:0] m_bvalid  = {m1_if.bvalid,  m0_if.bvalid};

  task automatic do_read(input int m, input logic [31:0] addr);
    int t;
    logic [31:0] d;
    logic [1:0]  r;
    m_araddr[m] = addr; m_arvalid[m] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!m_arready[m] && t < LIM);
    check($sformatf("m%0d ar handshake", m), 64'(m_arready[m]), 64'd1);
    @(posedge clk); #1;
    m_arvalid[m] = 1'b0; m_rready[m] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!m_rvalid[m] && t < LIM);
    check($sformatf("m%0d r handshake", m), 64'(m_rvalid[m]), 64'd1);
    d = (m == 1) ? m1_if.rdata : m0_if.rdata;
    r = (m == 1) ? m1_if.rresp : m0_if.rresp;
    @(posedge clk); #1;
    m_rready[m] = 1'b0;
    check($sformatf("m%0d rdata/rresp @%h", m, addr), 64'({r, d}), 64'({addr[3:2], ~addr}));
  endtask

  task automatic do_write(input int m, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] mask, input int wdel);
    int t;
    logic [1:0] r;
    m_awaddr[m] = addr; m_awvalid[m] = 1'b1;
    fork
      begin
        int ta = 0;
        do begin @(negedge clk); ta++; end while (!m_awready[m] && ta < LIM);
        check($sformatf("m%0d aw handshake", m), 64'(m_awready[m]), 64'd1);
        @(posedge clk); #1;
        m_awvalid[m] = 1'b0;
      end
      begin
        int tw = 0;
        if (wdel > 0) begin repeat (wdel) @(posedge clk); #1; end
        m_wdata[m] = data; m_wmask[m] = mask; m_wvalid[m] = 1'b1;
        do begin @(negedge clk); tw++; end while (!m_wready[m] && tw < LIM);
        check($sformatf("m%0d w handshake", m), 64'(m_wready[m]), 64'd1);
        @(posedge clk); #1;
        m_wvalid[m] = 1'b0;
      end
    join
    m_bready[m] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!m_bvalid[m] && t < LIM);
    check($sformatf("m%0d b handshake", m), 64'(m_bvalid[m]), 64'd1);
    r = (m == 1) ? m1_if.bresp : m0_if.bresp;
    @(posedge clk); #1;
    m_bready[m] = 1'b0;
    check($sformatf("m%0d bresp @%h", m, addr), 64'(r), 64'(addr[5:4]));
  endtask

  // ---------------- reactive slave with transaction log ----------------
  typedef struct packed {
    logic        kind;   // 0 read, 1 write
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } txn_t;

  txn_t slog[$];
  txn_t exp_q[$];
  int   ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0, b_lat = 0;
  int   proto_err = 0;

  initial begin
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    logic r_pend, aw_got, w_got;
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs, ar_seen, aw_seen, w_seen;
    logic [31:0] rd_addr, wr_addr, wr_data;
    logic [3:0]  wr_mask;
    s_if.arready = 1'b0; s_if.rvalid = 1'b0; s_if.rdata = 32'h0; s_if.rresp = 2'b00;
    s_if.awready = 1'b0; s_if.wready = 1'b0; s_if.bvalid = 1'b0; s_if.bresp = 2'b00;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    r_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
    rd_addr = 32'h0; wr_addr = 32'h0; wr_data = 32'h0; wr_mask = 4'h0;
    forever begin
      @(negedge clk);
      ar_seen = s_if.arvalid; aw_seen = s_if.awvalid; w_seen = s_if.wvalid;
      ar_hs = s_if.arvalid & s_if.arready;
      r_hs  = s_if.rvalid  & s_if.rready;
      aw_hs = s_if.awvalid & s_if.awready;
      w_hs  = s_if.wvalid  & s_if.wready;
      b_hs  = s_if.bvalid  & s_if.bready;
      // one transaction at a time, each address/data beat presented once
      if (s_if.arvalid && (r_pend || aw_got || w_got || s_if.awvalid || s_if.wvalid)) proto_err++;
      if (s_if.awvalid && (aw_got || r_pend)) proto_err++;
      if (s_if.wvalid && (w_got || r_pend)) proto_err++;
      if (ar_hs) rd_addr = s_if.araddr;
      if (aw_hs) wr_addr = s_if.awaddr;
      if (w_hs) begin wr_data = s_if.wdata; wr_mask = s_if.wmask; end
      if (r_hs) slog.push_back({1'b0, rd_addr, 32'h0, 4'h0});
      if (b_hs) slog.push_back({1'b1, wr_addr, wr_data, wr_mask});
      @(posedge clk); #1;
      if (reset) begin
        s_if.arready = 1'b0; s_if.rvalid = 1'b0; s_if.awready = 1'b0;
        s_if.wready = 1'b0; s_if.bvalid = 1'b0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        r_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
      end else begin
        if (ar_hs) begin s_if.arready = 1'b0; r_pend = 1'b1; r_cnt = 0; ar_cnt = 0; end
        else if (ar_seen && !r_pend) begin
          if (ar_cnt >= ar_lat) s_if.arready = 1'b1; else ar_cnt++;
        end
        if (r_hs) begin s_if.rvalid = 1'b0; r_pend = 1'b0; end
        else if (r_pend && !s_if.rvalid) begin
          if (r_cnt >= r_lat) begin
            s_if.rvalid = 1'b1; s_if.rdata = ~rd_addr; s_if.rresp = rd_addr[3:2];
          end else r_cnt++;
        end
        if (aw_hs) begin s_if.awready = 1'b0; aw_got = 1'b1; aw_cnt = 0; end
        else if (aw_seen && !aw_got) begin
          if (aw_cnt >= aw_lat) s_if.awready = 1'b1; else aw_cnt++;
        end
        if (w_hs) begin s_if.wready = 1'b0; w_got = 1'b1; w_cnt = 0; end
        else if (w_seen && !w_got) begin
          if (w_cnt >= w_lat) s_if.wready = 1'b1; else w_cnt++;
        end
        if (b_hs) begin s_if.bvalid = 1'b0; aw_got = 1'b0; w_got = 1'b0; b_cnt = 0; end
        else if (aw_got && w_got && !s_if.bvalid) begin
          if (b_cnt >= b_lat) begin s_if.bvalid = 1'b1; s_if.bresp = wr_addr[5:4]; end
          else b_cnt++;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] r_addr [2];
  logic [31:0] w_addr [2];
  logic [31:0] w_data [2];
  logic [3:0]  w_mask [2];
  bit          model_last = 1'b1;  // 1 => m0 wins a tie

  // Expected slave-side order for requests all raised together while the arbiter is idle
  task automatic build_expect(input logic [3:0] pat);
    bit rd[2], wr[2];
    int w;
    rd[0] = pat[0]; wr[0] = pat[1]; rd[1] = pat[2]; wr[1] = pat[3];
    exp_q.delete();
    while (rd[0] || wr[0] || rd[1] || wr[1]) begin
      if ((rd[0] || wr[0]) && (rd[1] || wr[1])) w = model_last ? 0 : 1;
      else w = (rd[1] || wr[1]) ? 1 : 0;
      model_last = (w == 1);
      if (rd[w]) begin exp_q.push_back({1'b0, r_addr[w], 32'h0, 4'h0}); rd[w] = 1'b0; end
      else begin exp_q.push_back({1'b1, w_addr[w], w_data[w], w_mask[w]}); wr[w] = 1'b0; end
    end
  endtask

  task automatic check_log(input string tag);
    check({tag, " txn count"}, 64'(slog.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < slog.size()) begin
        check($sformatf("%s txn%0d kind/addr", tag, i),
              64'({slog[i].kind, slog[i].addr}), 64'({exp_q[i].kind, exp_q[i].addr}));
        check($sformatf("%s txn%0d mask/data", tag, i),
              64'({slog[i].mask, slog[i].data}), 64'({exp_q[i].mask, exp_q[i].data}));
      end
    end
    check({tag, " protocol"}, 64'(proto_err), 64'd0);
  endtask

  task automatic run_round(input logic [3:0] pat, input int wdel0, input int wdel1, input string tag);
    build_expect(pat);
    slog.delete(); proto_err = 0;
    @(posedge clk); #1;
    fork
      if (pat[0]) do_read(0, r_addr[0]);
      if (pat[1]) do_write(0, w_addr[0], w_data[0], w_mask[0], wdel0);
      if (pat[2]) do_read(1, r_addr[1]);
      if (pat[3]) do_write(1, w_addr[1], w_data[1], w_mask[1], wdel1);
    join
    check_log(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int t;
    logic [3:0] pat;
    reset = 1'b1;
    m_arvalid = 2'b00; m_rready = 2'b00; m_awvalid = 2'b00; m_wvalid = 2'b00; m_bready = 2'b00;
    for (int i = 0; i < 2; i++) begin
      m_araddr[i] = 32'h0; m_awaddr[i] = 32'h0; m_wdata[i] = 32'h0; m_wmask[i] = 4'h0;
    end

    // requests raised during reset must not propagate
    m_arvalid[0] = 1'b1; m_awvalid[1] = 1'b1;
    repeat (3) @(negedge clk);
    check("outputs in reset",
          64'({s_if.arvalid, s_if.rready, s_if.awvalid, s_if.wvalid, s_if.bready,
               m_arready, m_rvalid, m_awready, m_wready, m_bvalid}), 64'd0);
    m_arvalid = 2'b00; m_awvalid = 2'b00;
    @(posedge clk); #1;
    reset = 1'b0;

    // single m0 read: registered grant, s.arvalid one cycle after the request
    r_addr[0] = 32'h8000_0000;
    r_lat = 2;
    build_expect(4'b0001);
    slog.delete(); proto_err = 0;
    @(posedge clk); #1;
    fork
      do_read(0, r_addr[0]);
      begin
        @(negedge clk);
        check("s.arvalid in arbitration cycle", 64'(s_if.arvalid), 64'd0);
        @(negedge clk);
        check("s.ar one cycle later", 64'({s_if.arvalid, s_if.araddr}), 64'({1'b1, 32'h8000_0000}));
      end
    join
    check_log("m0 read");
    r_lat = 0;

    // m1 write with W one cycle after AW
    w_addr[1] = 32'ha000_03f8; w_data[1] = 32'h0000_0041; w_mask[1] = 4'hf;
    run_round(4'b1000, 0, 1, "m1 write late W");

    // AW held off three cycles while W is accepted at once
    aw_lat = 3;
    w_addr[0] = 32'h0000_1230; w_data[0] = 32'hdead_beef; w_mask[0] = 4'h3;
    run_round(4'b0010, 0, 0, "m0 write early W");
    aw_lat = 0;

    // reset while m1 waits for read data, then a clean m0 read
    r_lat = 40;
    slog.delete();
    @(posedge clk); #1;
    m_araddr[1] = 32'h4000_0010; m_arvalid[1] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!m_arready[1] && t < LIM);
    check("m1 ar before reset", 64'(m_arready[1]), 64'd1);
    @(posedge clk); #1;
    m_arvalid[1] = 1'b0; m_rready[1] = 1'b1;
    repeat (3) @(negedge clk);
    check("s.rready during RD_M1", 64'(s_if.rready), 64'd1);
    #2 reset = 1'b1;
    #1 check("outputs right after async reset",
             64'({s_if.arvalid, s_if.rready, s_if.awvalid, s_if.wvalid, s_if.bready,
                  m_arready, m_rvalid, m_awready, m_wready, m_bvalid}), 64'd0);
    m_rready[1] = 1'b0;
    r_lat = 0;
    model_last = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    r_addr[0] = 32'h8000_0040;
    run_round(4'b0001, 0, 0, "read after reset");

    // randomized rounds: all requests raised together, arbiter idle at start
    for (int r = 0; r < 40; r++) begin
      if (r < 2) pat = 4'b0101;
      else if (r == 2) pat = 4'b1100;
      else pat = 4'($urandom_range(1, 15));
      for (int i = 0; i < 2; i++) begin
        r_addr[i] = $urandom; w_addr[i] = $urandom; w_data[i] = $urandom;
        w_mask[i] = 4'($urandom_range(0, 15));
      end
      ar_lat = $urandom_range(0, 3); r_lat = $urandom_range(0, 3);
      aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3); b_lat = $urandom_range(0, 3);
      run_round(pat, $urandom_range(0, 2), $urandom_range(0, 2), $sformatf("round%0d", r));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
